// File: rtl/count_sequencer_pkg.sv
// count_sequencer shared types.
// State encoding and counter data width.
package count_sequencer_pkg;

  localparam int DW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/count_sequencer_if.sv
// Command/status and counter-side bundle
// between a controller host and count_sequencer.
interface count_sequencer_if #(
  parameter int PW = 4
);
  import count_sequencer_pkg::*;

  logic          start;
  logic          stop;
  logic [DW-1:0] pre;
  logic [DW-1:0] term;
  logic [PW-1:0] div;
  logic [DW-1:0] r;
  logic          c;
  logic          l;
  logic [DW-1:0] i;
  logic          busy;
  logic          done;

  modport slave (
    input  start, stop, pre, term, div, r,
    output c, l, i, busy, done
  );

  modport master (
    output start, stop, pre, term, div, r,
    input  c, l, i, busy, done
  );

endinterface

// File: rtl/count_sequencer_prescale_tick.sv
// Prescale counter: ticks when pcnt reaches div_q,
// then wraps to 0.
module prescale_tick #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [PW-1:0] div_q,
  output logic          tick
);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;

  assign tick = (pcnt_q == div_q);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clear) begin
      pcnt_d = '0;
    end else if (enable) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Sequencer for a 4-bit loadable counter:
// load preload, strobe count every div+1 cycles up to term.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int PW = 4
) (
  input  logic           clk,
  input  logic           t,
  count_sequencer_if.slave bus
);

  state_e        state_q;
  state_e        state_d;
  logic [DW-1:0] pre_q;
  logic [DW-1:0] pre_d;
  logic [DW-1:0] term_q;
  logic [DW-1:0] term_d;
  logic [PW-1:0] div_q;
  logic [PW-1:0] div_d;
  logic          l_q;
  logic          l_d;
  logic          busy_q;
  logic          busy_d;
  logic          done_q;
  logic          done_d;
  logic          tick;
  logic          hit;
  logic          c_int;
  logic          p_clr;
  logic          p_en;

  assign hit   = (bus.r == term_q);
  assign p_en  = (state_q == S_RUN);
  assign p_clr = (state_q != S_RUN) | bus.stop | hit;

  prescale_tick #(
    .PW(PW)
  ) u_tick (
    .clk    (clk),
    .rst    (t),
    .clear  (p_clr),
    .enable (p_en),
    .div_q  (div_q),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    term_d  = term_q;
    div_d   = div_q;
    c_int   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pre_d   = bus.pre;
          term_d  = bus.term;
          div_d   = bus.div;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = bus.stop ? S_IDLE : S_RUN;
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (hit) begin
          state_d = S_DONE;
        end else begin
          c_int = tick;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (t) begin
      state_d = S_IDLE;
      pre_d   = '0;
      term_d  = '0;
      div_d   = '0;
    end
    l_d    = (state_d == S_LOAD);
    busy_d = (state_d == S_LOAD) | (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (t) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      term_q  <= '0;
      div_q   <= '0;
      l_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      term_q  <= term_d;
      div_q   <= div_d;
      l_q     <= l_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Counter favours count over reset, so t must mask the strobe.
  assign bus.c    = c_int & ~t;
  assign bus.l    = l_q;
  assign bus.i    = pre_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer with a
// behavioural 4-bit loadable counter on the feedback path.
module tb_count_sequencer;
  import count_sequencer_pkg::*;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic t;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  ev_t  sb[$];
  ev_t  m_e;
  int   m_kind;
  int   k;

  count_sequencer_if #(.PW(4)) bus ();

  count_sequencer #(.PW(4)) dut (
    .clk (clk),
    .t   (t),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter: count beats reset, reset beats load.
  always @(posedge clk) begin
    if (bus.c) bus.r <= bus.r + 4'd1;
    else if (t) bus.r <= '0;
    else if (bus.l) bus.r <= bus.i;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // kind: 0 = load, 1 = count strobe, 2 = done
  always @(negedge clk) begin
    if (bus.c || bus.l) chk("c_l_excl", 32'(bus.c & bus.l), 0);
    if (bus.l || bus.c || bus.done) begin
      m_kind = bus.l ? 0 : (bus.c ? 1 : 2);
      if (sb.size() == 0) begin
        chk("sb_unexpected_cycle", cyc, -1);
      end else begin
        m_e = sb.pop_front();
        chk("ev_kind", m_kind, m_e.kind);
        chk("ev_cycle", cyc, m_e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c0);
    ev_t e;
    e.kind = kind;
    e.cyc  = c0;
    sb.push_back(e);
  endtask

  task automatic launch(input int p, input int tm, input int dv,
                        input bit full, output int k0);
    int n;
    k0 = cyc;
    n  = (tm - p) & 15;
    push(0, k0 + 1);
    if (full) begin
      for (int j = 0; j < n; j++) push(1, k0 + 2 + j * (dv + 1) + dv);
      push(2, k0 + 3 + n * (dv + 1));
    end
    bus.start = 1'b1;
    bus.pre   = 4'(p);
    bus.term  = 4'(tm);
    bus.div   = 4'(dv);
    tick(1);
    bus.start = 1'b0;
  endtask

  initial begin
    t         = 1'b1;
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    bus.pre   = 4'd5;
    bus.term  = 4'd6;
    bus.div   = 4'd0;
    tick(1);
    chk("rst_l", bus.l, 0);
    chk("rst_c", bus.c, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_i", bus.i, 0);
    tick(1);
    chk("rst2_l", bus.l, 0);
    chk("rst2_busy", bus.busy, 0);
    chk("rst2_r", bus.r, 0);
    t         = 1'b0;
    bus.start = 1'b0;
    tick(2);

    // basic run, with an ignored start while busy
    launch(3, 7, 2, 1'b1, k);
    chk("a_busy", bus.busy, 1);
    tick(5);
    bus.start = 1'b1;
    bus.pre   = 4'd0;
    bus.term  = 4'd15;
    bus.div   = 4'd0;
    tick(1);
    bus.start = 1'b0;
    tick(10);
    chk("a_r", bus.r, 7);
    chk("a_busy_end", bus.busy, 0);
    chk("a_sb_empty", sb.size(), 0);

    // wrap-around 14 -> 2
    launch(14, 2, 0, 1'b1, k);
    tick(8);
    chk("b_r", bus.r, 2);
    chk("b_sb_empty", sb.size(), 0);

    // pre == term
    launch(9, 9, 5, 1'b1, k);
    tick(5);
    chk("c_r", bus.r, 9);
    chk("c_sb_empty", sb.size(), 0);

    // stop in RUN after two steps
    launch(0, 10, 1, 1'b0, k);
    push(1, k + 3);
    push(1, k + 5);
    tick(5);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("d_busy", bus.busy, 0);
    chk("d_done", bus.done, 0);
    tick(4);
    chk("d_r", bus.r, 2);
    chk("d_sb_empty", sb.size(), 0);
    launch(2, 4, 0, 1'b1, k);
    tick(6);
    chk("d2_r", bus.r, 4);
    chk("d2_sb_empty", sb.size(), 0);

    // stop in LOAD: counter still loads
    launch(6, 1, 0, 1'b0, k);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("e_busy", bus.busy, 0);
    tick(3);
    chk("e_r", bus.r, 6);
    chk("e_sb_empty", sb.size(), 0);

    // reset while a strobe is due
    launch(0, 5, 0, 1'b0, k);
    push(1, k + 2);
    push(1, k + 3);
    tick(3);
    t = 1'b1;
    #1;
    chk("f_c_gated", bus.c, 0);
    tick(1);
    t = 1'b0;
    chk("f_r", bus.r, 0);
    chk("f_busy", bus.busy, 0);
    chk("f_i", bus.i, 0);
    tick(1);
    launch(1, 3, 1, 1'b1, k);
    tick(8);
    chk("f2_r", bus.r, 3);
    chk("f2_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Upstream controller for the 4-bit loadable counter: accepts a start command with a preload value, a terminal value and a prescale divisor, then drives the counter's load, load-data and count-enable inputs. It loads the preload, issues one count strobe every div+1 cycles until the counter output equals the terminal value, then pulses done. It monitors the counter output directly and never asserts load and count in the same cycle.

## Interface
- PW, default 4: prescale divisor width.
- clk  in  1  system clock, rising edge.
- t  in  1  synchronous active-high reset, shared with the counter.
- start  in  1  launch command, sampled only in IDLE.
- stop  in  1  abort command, effective in LOAD and RUN.
- pre  in  4  preload value, latched on accepted start.
- term  in  4  terminal value, latched on accepted start.
- div  in  PW  prescale divisor, latched on accepted start; step period is div+1 cycles.
- r  in  4  counter output, fed back from the counter.
- c  out  1  count enable to the counter.
- l  out  1  load enable to the counter.
- i  out  4  load data to the counter.
- busy  out  1  high in LOAD and RUN.
- done  out  1  single-cycle completion pulse.

## Operation
- States:
  - IDLE: busy=0; start=1 latches pre/term/div into pre_q/term_q/div_q and goes to LOAD.
  - LOAD: l=1 for exactly one cycle, then RUN; pcnt cleared.
  - RUN: each cycle the following are evaluated in order:
    - stop=1 → IDLE, no done.
    - r==term_q → DONE; c=0 this cycle.
    - pcnt==div_q → c=1, pcnt←0.
    - otherwise → pcnt←pcnt+1.
  - DONE: done=1 for one cycle, then IDLE.
- stop in LOAD → IDLE; the counter still loads on that edge. stop in IDLE/DONE is ignored.
- start while not in IDLE is ignored. There is no queuing.
- i = pre_q at all times; pre_q resets to 0.
- c and l are never both 1. The counter gives count priority over load, so this is a hard invariant.
- c = c_int & ~t, combinationally gated. The counter gives count priority over its reset, so c must be 0 in any cycle where t=1.
- Step count N = (term − pre) mod 16, so wrap-around is intentional. Example: pre=14, term=2 steps through 15, 0, 1, 2 (N=4).
- pre==term gives N=0: no c strobes, done still pulses.
- Arithmetic: pcnt is PW bits and never exceeds div_q. div_q=0 strobes c every RUN cycle until term is reached.
- t=1 in any state: next state IDLE; pcnt, pre_q, term_q, div_q ← 0; busy=0, done=0. The counter clears in the same cycle.

## Timing
- Reset values: c=0, l=0, i=0, busy=0, done=0, state IDLE.
- start high in cycle 0 (IDLE) → l=1 and busy=1 in cycle 1 → RUN begins in cycle 2 with r==pre.
- Step j (j=0..N−1) has c=1 in cycle 2 + j(div+1) + div. The counter output updates in the following cycle.
- r==term is detected in cycle 2 + N(div+1). done=1 in cycle 3 + N(div+1). busy is 0 from the done cycle onward.
- A new start is accepted in the cycle after done, which is the IDLE cycle.
- busy, done and l are registered state decodes. c is combinational from state, pcnt, r, term_q and t.

## Structure
- Shared package holds state encodings (IDLE, LOAD, RUN, DONE; 2-bit) and the counter data width constant (4).
- One natural sub-module: prescale_tick.
  - Holds pcnt; inputs clear/enable/div_q; output tick when pcnt==div_q.
- The FSM, operand registers and output gating stay in count_sequencer.

## Test plan
- Reset: t=1 for 2 cycles with start=1 → all outputs 0, state IDLE, no l and no c.
- pre=3, term=7, div=2: l=1 in cycle 1. c pulses in cycles 4, 7, 10, 13. done in cycle 15. The counter ends at 7.
- Wrap-around, pre=14, term=2, div=0: c in cycles 2–5. The counter passes 15→0. done in cycle 7.
- pre=term=9: l pulse, zero c strobes, done in cycle 3.
- stop asserted in RUN after 2 steps (pre=0, term=10, div=1): busy drops next cycle, no done, c stays 0, and the counter holds at 2. A new start is then accepted.
- t asserted mid-RUN in a cycle where c_int=1: c=0 that cycle, the counter reads 0, the controller is IDLE, and a later start is ignored while busy only if issued before IDLE.
